// File: rtl/conv_layer_sequencer_if.sv
// Output-plane write channel of conv_layer_sequencer.
//   out_valid : plane write request (sequencer -> buffer)
//   out_ready : buffer accepts; transfer on out_valid & out_ready
//   out_ch    : channel index of the plane being written
//   out_data  : packed output plane (PW bits)
// master = sequencer side, slave = layer output buffer side.
interface conv_layer_sequencer_if #(
    parameter int OCW = 4,
    parameter int PW  = 784
) ();
    logic           out_valid;
    logic           out_ready;
    logic [OCW-1:0] out_ch;
    logic [PW-1:0]  out_data;

    modport master (output out_valid, output out_ch, output out_data, input out_ready);
    modport slave  (input out_valid, input out_ch, input out_data, output out_ready);
endinterface

// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
// Runs one binary convolution layer by time-multiplexing a single conv core
// over OC output channels. Per channel: present the channel index to the
// weight ROM, latch the returned IC*9-bit word into core_weights, enable the
// core until it reports done, capture its plane and write it out.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      layer start (sampled in IDLE) / abandon layer
//   busy, done        non-IDLE indicator / one-cycle layer-complete pulse
//   wt_addr, wt_data  weight ROM address (= channel) and 1-cycle-latency data
//   core_weights      weights held stable for the core during a pass
//   core_en           core run enable; low clears the core
//   core_done,core_img core completion pulse and its output plane
//   wr                output-plane write channel (conv_layer_sequencer_if.master)
//
// Optional: define CONV_SEQ_PERF_EN to add perf_cycles (busy cycles) and
// perf_stall (WRITE cycles with out_ready low), both saturating 32-bit.
module conv_layer_sequencer #(
    parameter int OC           = 16,
    parameter int IC           = 8,
    parameter int IMG_OUT_SIZE = 28,
    parameter int OCW          = ($clog2(OC) > 0) ? $clog2(OC) : 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   abort,
    output logic                                   busy,
    output logic                                   done,
    output logic [OCW-1:0]                         wt_addr,
    input  logic [IC*9-1:0]                        wt_data,
    output logic [IC*9-1:0]                        core_weights,
    output logic                                   core_en,
    input  logic                                   core_done,
    input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0]   core_img,
    conv_layer_sequencer_if.master                 wr
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]                            perf_cycles,
    output logic [31:0]                            perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_RUN,
        S_WRITE
    } state_t;

    state_t         state_reg;
    logic [OCW-1:0] ch_reg;

    // The ROM address is simply the current channel register.
    assign wt_addr = ch_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            ch_reg       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            core_en      <= 1'b0;
            core_weights <= '0;
            wr.out_valid <= 1'b0;
            wr.out_ch    <= '0;
            wr.out_data  <= '0;
        end else begin
            done <= 1'b0;
            if (abort && (state_reg != S_IDLE)) begin
                // Abort wins over every other transition; the captured plane
                // is dropped by simply never presenting it again.
                state_reg    <= S_IDLE;
                busy         <= 1'b0;
                core_en      <= 1'b0;
                wr.out_valid <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            ch_reg    <= '0;
                            busy      <= 1'b1;
                            state_reg <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // wt_addr is valid this cycle; ROM data arrives in LOAD.
                        state_reg <= S_LOAD;
                    end
                    S_LOAD: begin
                        core_weights <= wt_data;
                        core_en      <= 1'b1;
                        state_reg    <= S_RUN;
                    end
                    S_RUN: begin
                        if (core_done) begin
                            wr.out_data  <= core_img;
                            wr.out_ch    <= ch_reg;
                            wr.out_valid <= 1'b1;
                            // Dropping the enable right away clears the core so
                            // it cannot start another pass on its own.
                            core_en      <= 1'b0;
                            state_reg    <= S_WRITE;
                        end
                    end
                    S_WRITE: begin
                        if (wr.out_ready) begin
                            wr.out_valid <= 1'b0;
                            if (ch_reg == OCW'(OC - 1)) begin
                                done      <= 1'b1;
                                busy      <= 1'b0;
                                state_reg <= S_IDLE;
                            end else begin
                                ch_reg    <= ch_reg + 1'b1;
                                state_reg <= S_FETCH;
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef CONV_SEQ_PERF_EN
    // Counters restart when a layer starts and otherwise hold in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if ((state_reg == S_IDLE) && start) begin
            perf_cycles <= '0;
            perf_stall  <= '0;
        end else if (state_reg != S_IDLE) begin
            if (perf_cycles != 32'hFFFF_FFFF) begin
                perf_cycles <= perf_cycles + 32'd1;
            end
            if ((state_reg == S_WRITE) && !wr.out_ready && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/conv_layer_sequencer.md
Name: conv_layer_sequencer

Overview:
- Sequences one binary convolution layer over OC output channels by time-multiplexing a single conv core (one output channel per pass).
- For each channel: fetches the IC*9-bit packed weight word from the weight ROM, runs the core, captures its output plane, and writes it to the layer output buffer.
- Sits between the network top-level controller (start/done) and the conv core, weight ROM and feature-map buffer.

Parameters:
- OC, 16, number of output channels (passes per layer); >=1.
- IC, 8, input channels; sets the weight word width IC*9.
- IMG_OUT_SIZE, 28, output plane side; plane width PW = IMG_OUT_SIZE*IMG_OUT_SIZE.
- OCW, $clog2(OC)>0?$clog2(OC):1, width of channel indices.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled only in IDLE; begins a layer.
- abort  in  1  abandon the layer; return to IDLE next cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last channel's write is accepted.
- wt_addr  out  OCW  weight ROM address = current channel index.
- wt_data  in  IC*9  ROM read data, valid exactly 1 cycle after wt_addr is presented.
- core_weights  out  IC*9  registered weights driven to the core.
- core_en  out  1  drives the core's data_in_ready; low clears the core.
- core_done  in  1  core's data_out_ready one-cycle pulse.
- core_img  in  PW  core output plane; valid in the cycle core_done=1.
- out_valid  out  1  output-plane write request.
- out_ready  in  1  output buffer accept; transfer when out_valid & out_ready.
- out_ch  out  OCW  channel index of the plane being written.
- out_data  out  PW  captured output plane.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ch=0; busy=0, done=0, core_en=0, out_valid=0, wt_addr=0, out_ch=0, core_weights=0, out_data=0.
- IDLE: start=1 -> ch<=0, go to FETCH.
- FETCH (1 cycle): wt_addr=ch; core_en=0 -> LOAD.
- LOAD (1 cycle): core_weights<=wt_data -> RUN.
- RUN: core_en=1. Weights are stable for the whole pass. On core_done=1: out_data<=core_img, out_ch<=ch, core_en<=0, go to WRITE. core_en is low in the cycle after core_done, so the core clears and never re-runs unseen.
- WRITE: out_valid=1; out_data/out_ch held stable until accepted.
  - Accept, ch==OC-1 -> done pulse, go to IDLE.
  - Accept, otherwise -> ch<=ch+1, go to FETCH.
- core_en is therefore low for >=2 cycles between passes (WRITE accept, FETCH, LOAD); the core restarts from row 0, col 0 each pass.
- Per-channel latency, out_ready tied 1: 2 (FETCH+LOAD) + (IC+1)*PW (core) + 1 (WRITE) cycles.
- core_done outside RUN: ignored.
- start while busy: ignored. start held high at done: a new layer starts on the cycle after returning to IDLE.
- abort (priority over all transitions, any non-IDLE state): next state IDLE; core_en=0, out_valid=0, no done pulse; in-flight plane discarded.
- OC=1: single pass, then done.
- ch never exceeds OC-1; no wrap-around beyond the layer.
- Async reset mid-pass: all outputs return to reset values immediately; core_en=0 clears the core.

Optional Feature:
- Macro: CONV_SEQ_PERF_EN.
- Defined:
  - Adds output perf_cycles (32 bits). Clears on the IDLE->FETCH transition and increments every busy cycle, saturating at 2^32-1.
  - Holds its value in IDLE until the next start.
  - Adds output perf_stall (32 bits), counting WRITE cycles with out_ready=0, same clear/saturate rules.
- Undefined: neither port nor counters exist; all other behaviour identical.

Test Plan:
- OC=2, IC=1, IMG_OUT_SIZE=2, out_ready=1, core model with done after (IC+1)*4=8 cycles of core_en:
  - wt_addr sequence 0 then 1; two writes with out_ch=0 then 1.
  - done pulses exactly once, 2*(2+8+1)=22 cycles after leaving IDLE.
- Backpressure: out_ready=0 for 5 cycles in WRITE -> out_valid, out_data, out_ch held constant; core_en stays 0; ch advances only on accept.
- Weight load: ROM word for ch1 = 9'h1A5 -> core_weights==9'h1A5 throughout ch1's RUN; core_en low for >=2 cycles between passes.
- abort asserted mid-RUN of ch0 -> next cycle IDLE, busy=0, core_en=0, no out_valid, no done; a following start begins at wt_addr=0.
- Async rst asserted mid-WRITE (not clock-aligned) -> out_valid and busy drop immediately without a clock edge; spurious core_done in IDLE is ignored.
- With CONV_SEQ_PERF_EN, first scenario: perf_cycles==22 after done, perf_stall==0; with the 5-cycle stall, perf_stall==5 and perf_cycles==27.
